xadac_vadd_unit: RTL and testbench
==================================

// Module: xadac_vadd_unit
// PURPOSE
//  Execution responder terminating an xadac_if at its slave end; the counterpart of the register-file stage.
//  Answers decode queries for the custom vector add/sub group.
//  Executes accepted ops lane-wise on VecDataT operands and returns vd results.
//  Two-stage valid/ready pipeline with full throughput and complete backpressure.
// PARAMETERS
//  LaneW8En   1  enable 8-bit lane ops (VADD8/VSUB8); disabled ops decode as not accepted
//  LaneW16En  1  enable 16-bit lane ops (VADD16/VSUB16)
// PORTS
//  clk   in   1      clock, all state on rising edge
//  rstn  in   1      asynchronous active-low reset
//  slv   modport xadac_if.slv  dec_req/dec_rsp and exe_req/exe_rsp channels, each valid/ready; VecDataT = VLEN bits
// BEHAVIOUR
//  Reset: dec_rsp_valid=0, exe_rsp_valid=0, all pipeline valids 0, data regs 0; dec_req_ready=1, exe_req_ready=1.
//  Handshake: transfer when valid&&ready; valid never drops and payload never changes while ready=0.
//  Decode channel: 1-entry response register, 1-cycle latency.
//   dec_req_ready = !dec_vld || dec_rsp_ready (accept and drain in the same cycle allowed).
//   accept = (opcode==XadacOpcVec) && (funct7==XadacF7Vadd) && funct3 in enabled op set.
//   dec_rsp: id echoed; accept as above; vs_read='b011 (vs1,vs2); rs_read=0; vd_write=accept.
//  Exe pipeline: S1 operand register -> ALU -> S2 result register; exe_rsp driven from S2.
//   exe_req_ready = !s1_vld || s2_ready; s2_ready = !s2_vld || exe_rsp_ready.
//   Latency: request accepted in cycle N -> exe_rsp_valid in N+2 with no stall; 1 op/cycle sustained.
//   exe_rsp: id echoed, vd_addr = instr[11:7], vd_data = result, vd_write=1.
//   An op not in the enabled set at exe: vd_write=0, vd_data=0, id still returned (never dropped).
//  Arithmetic: vd = vs_data[0] op vs_data[1] per lane, lane width 8/16/32 per funct3.
//   Lanes wrap modulo 2^W; no carry or borrow crosses lane boundaries; VLEN must be a multiple of 32.
//  Ordering: responses leave strictly in acceptance order; the two channels are independent.
//  Simultaneous events: S2 drain + S1 advance + new accept in one cycle all legal when exe_rsp_ready=1.
//  Full: S1 and S2 valid with exe_rsp_ready=0 -> exe_req_ready=0 the same cycle (combinational).
//  Reset mid-operation: all in-flight ops are discarded, outputs return to reset values immediately.
// STRUCTURE
//  xadac_pkg additions: XadacOpcVec, XadacF7Vadd, funct3 codes VADD8/16/32, VSUB8/16/32, enum VaddOpT.
//  xadac_pkg additions: function vadd_op_decode(instr) -> {VaddOpT, legal}, shared with other decode users.
//  Sub-module xadac_vadd_alu: combinational, (a, b, op) -> VecDataT; generate loop per 32-bit slice.
//  All pipeline and channel registers live in the top module.
// TESTING
//  Decode VADD8, then an illegal funct7 -> dec_rsp accept=1 id=3, then accept=0 id=4, each 1 cycle after request.
//  VADD8 with lanes 0xFF+0x01 -> lane 0x00, neighbour lane unchanged (no carry); rsp at N+2, vd_addr=instr[11:7].
//  VSUB16 with 0x0000-0x0001 -> 0xFFFF per lane; VADD32 0x7FFFFFFF+1 -> 0x80000000.
//  Back-to-back 8 ops with exe_rsp_ready=1 -> 8 responses on consecutive cycles, ids in order.
//  exe_rsp_ready=0 for 5 cycles -> exe_req_ready falls after 2 accepts; data held stable; resume with no loss.
//  rstn pulsed low with 2 ops in flight -> exe_rsp_valid=0 at once; no stale response after release.

Source files
------------

// File: rtl/xadac_pkg.sv
// xadac_pkg: shared types and constants for the xadac coprocessor interface.
//   Channel payload structs for dec_req/dec_rsp and exe_req/exe_rsp,
//   encodings for the custom vector add/sub group, and the decode helper
//   vadd_op_decode() used by every stage that has to recognise these ops.
package xadac_pkg;

    localparam int VLEN = 128;  // vector length in bits; must be a multiple of 32
    localparam int IdW  = 4;

    typedef logic [VLEN-1:0] VecDataT;
    typedef logic [IdW-1:0]  IdT;

    // Custom-0 major opcode carries the vector group; funct7 selects add/sub.
    localparam logic [6:0] XadacOpcVec = 7'b0001011;
    localparam logic [6:0] XadacF7Vadd = 7'b0000101;

    localparam logic [2:0] F3Vadd8  = 3'd0;
    localparam logic [2:0] F3Vadd16 = 3'd1;
    localparam logic [2:0] F3Vadd32 = 3'd2;
    localparam logic [2:0] F3Vsub8  = 3'd4;
    localparam logic [2:0] F3Vsub16 = 3'd5;
    localparam logic [2:0] F3Vsub32 = 3'd6;

    typedef enum logic [2:0] {
        OpVadd8, OpVadd16, OpVadd32, OpVsub8, OpVsub16, OpVsub32
    } VaddOpT;

    typedef enum logic [1:0] {Lane8, Lane16, Lane32} LaneT;

    typedef struct packed {
        VaddOpT op;
        logic   legal;
    } vadd_dec_t;

    typedef struct packed {
        logic [31:0] instr;
        IdT          id;
    } xadac_dec_req_t;

    typedef struct packed {
        IdT         id;
        logic       accept;
        logic [2:0] vs_read;
        logic [1:0] rs_read;
        logic       vd_write;
    } xadac_dec_rsp_t;

    typedef struct packed {
        IdT                id;
        logic [31:0]       instr;
        VecDataT [1:0]     vs_data;
    } xadac_exe_req_t;

    typedef struct packed {
        IdT         id;
        logic [4:0] vd_addr;
        VecDataT    vd_data;
        logic       vd_write;
    } xadac_exe_rsp_t;

    // Recognises the encoding only; lane-width enables are applied by the user.
    function automatic vadd_dec_t vadd_op_decode(input logic [31:0] instr);
        vadd_dec_t d;
        d.op    = OpVadd8;
        d.legal = (instr[6:0] == XadacOpcVec) && (instr[31:25] == XadacF7Vadd);
        case (instr[14:12])
            F3Vadd8:  d.op = OpVadd8;
            F3Vadd16: d.op = OpVadd16;
            F3Vadd32: d.op = OpVadd32;
            F3Vsub8:  d.op = OpVsub8;
            F3Vsub16: d.op = OpVsub16;
            F3Vsub32: d.op = OpVsub32;
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic vadd_op_is_sub(input VaddOpT op);
        return (op == OpVsub8) || (op == OpVsub16) || (op == OpVsub32);
    endfunction

    function automatic LaneT vadd_op_lane(input VaddOpT op);
        case (op)
            OpVadd8,  OpVsub8:  return Lane8;
            OpVadd16, OpVsub16: return Lane16;
            default:            return Lane32;
        endcase
    endfunction

endpackage

// File: rtl/xadac_if.sv
// xadac_if: coprocessor link with a decode channel and an execute channel,
//   each a valid/ready request plus a valid/ready response.
//   mst: issuing side (core / register-file stage)
//   slv: execution responder
interface xadac_if;
    import xadac_pkg::*;

    logic           dec_req_valid;
    logic           dec_req_ready;
    xadac_dec_req_t dec_req;
    logic           dec_rsp_valid;
    logic           dec_rsp_ready;
    xadac_dec_rsp_t dec_rsp;

    logic           exe_req_valid;
    logic           exe_req_ready;
    xadac_exe_req_t exe_req;
    logic           exe_rsp_valid;
    logic           exe_rsp_ready;
    xadac_exe_rsp_t exe_rsp;

    modport mst (
        output dec_req_valid, dec_req, input dec_req_ready,
        input  dec_rsp_valid, dec_rsp, output dec_rsp_ready,
        output exe_req_valid, exe_req, input exe_req_ready,
        input  exe_rsp_valid, exe_rsp, output exe_rsp_ready
    );

    modport slv (
        input  dec_req_valid, dec_req, output dec_req_ready,
        output dec_rsp_valid, dec_rsp, input dec_rsp_ready,
        input  exe_req_valid, exe_req, output exe_req_ready,
        output exe_rsp_valid, exe_rsp, input exe_rsp_ready
    );
endinterface

// File: rtl/xadac_vadd_alu.sv
// xadac_vadd_alu: combinational lane-wise add/sub over a full vector.
//   a, b : source vectors
//   op   : operation (selects add/sub and lane width 8/16/32)
//   y    : result; every lane wraps modulo 2^W, nothing crosses a lane
// The vector is processed as independent 32-bit slices; narrower lanes are
// computed inside each slice so no carry/borrow ever leaks between lanes.
module xadac_vadd_alu
    import xadac_pkg::*;
(
    input  VecDataT a,
    input  VecDataT b,
    input  VaddOpT  op,
    output VecDataT y
);

    logic is_sub;
    LaneT lane;

    assign is_sub = vadd_op_is_sub(op);
    assign lane   = vadd_op_lane(op);

    for (genvar g = 0; g < VLEN / 32; g++) begin : g_slice
        logic [31:0] sa, sb, res;

        assign sa = a[32*g +: 32];
        assign sb = b[32*g +: 32];

        always_comb begin
            // NOTE: default every output first so no path leaves it unassigned (no latch).
            res = '0;
            case (lane)
                Lane8: begin
                    for (int l = 0; l < 4; l++)
                        res[8*l +: 8] = is_sub ? sa[8*l +: 8] - sb[8*l +: 8]
                                               : sa[8*l +: 8] + sb[8*l +: 8];
                end
                Lane16: begin
                    for (int l = 0; l < 2; l++)
                        res[16*l +: 16] = is_sub ? sa[16*l +: 16] - sb[16*l +: 16]
                                                 : sa[16*l +: 16] + sb[16*l +: 16];
                end
                default: res = is_sub ? sa - sb : sa + sb;
            endcase
        end

        assign y[32*g +: 32] = res;
    end

endmodule

// File: rtl/xadac_vadd_unit.sv
// xadac_vadd_unit: execution responder for the vector add/sub group.
//   clk  : clock, all state on rising edge
//   rstn : asynchronous active-low reset
//   slv  : xadac_if slave end (dec_req/dec_rsp, exe_req/exe_rsp)
// Decode: one response register, 1-cycle latency, accept+drain same cycle.
// Execute: S1 operand register -> ALU -> S2 result register -> exe_rsp.
//   Full throughput; backpressure ripples combinationally through the readies.
module xadac_vadd_unit
    import xadac_pkg::*;
#(
    parameter bit LaneW8En  = 1'b1,
    parameter bit LaneW16En = 1'b1
)
(
    input logic  clk,
    input logic  rstn,
    xadac_if.slv slv
);

    function automatic logic op_enabled(input VaddOpT op);
        case (vadd_op_lane(op))
            Lane8:   return LaneW8En;
            Lane16:  return LaneW16En;
            default: return 1'b1;
        endcase
    endfunction

    // ---------------- decode channel ----------------
    vadd_dec_t      dec_d;
    logic           dec_accept;
    logic           dec_vld;
    logic           dec_req_ready;
    xadac_dec_rsp_t dec_rsp_q;

    always_comb begin
        dec_d      = vadd_op_decode(slv.dec_req.instr);
        dec_accept = dec_d.legal && op_enabled(dec_d.op);
    end

    assign dec_req_ready = !dec_vld || slv.dec_rsp_ready;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dec_vld   <= 1'b0;
            // NOTE: payload registers are reset too so outputs are fully defined after reset.
            dec_rsp_q <= '0;
        end else if (dec_req_ready) begin
            dec_vld <= slv.dec_req_valid;
            if (slv.dec_req_valid) begin
                dec_rsp_q.id       <= slv.dec_req.id;
                dec_rsp_q.accept   <= dec_accept;
                dec_rsp_q.vs_read  <= 3'b011;
                dec_rsp_q.rs_read  <= 2'b00;
                dec_rsp_q.vd_write <= dec_accept;
            end
        end
    end

    assign slv.dec_req_ready = dec_req_ready;
    assign slv.dec_rsp_valid = dec_vld;
    assign slv.dec_rsp       = dec_rsp_q;

    // ---------------- execute pipeline ----------------
    typedef struct packed {
        IdT         id;
        VaddOpT     op;
        logic       en;        // op is in the enabled set
        logic [4:0] vd_addr;
        VecDataT    a;
        VecDataT    b;
    } s1_t;

    vadd_dec_t      exe_d;
    logic           s1_vld;
    s1_t            s1_q;
    logic           s2_vld;
    xadac_exe_rsp_t s2_q;
    logic           s2_ready;
    logic           exe_req_ready;
    VecDataT        alu_y;

    assign exe_d = vadd_op_decode(slv.exe_req.instr);

    assign s2_ready      = !s2_vld || slv.exe_rsp_ready;
    assign exe_req_ready = !s1_vld || s2_ready;

    xadac_vadd_alu u_alu (
        .a  (s1_q.a),
        .b  (s1_q.b),
        .op (s1_q.op),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
            s2_vld <= 1'b0;
            s2_q   <= '0;
        end else begin
            if (s2_ready) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    // Disabled ops still return their id so the issuer never loses track.
                    s2_q.id       <= s1_q.id;
                    s2_q.vd_addr  <= s1_q.vd_addr;
                    s2_q.vd_data  <= s1_q.en ? alu_y : '0;
                    s2_q.vd_write <= s1_q.en;
                end
            end
            if (exe_req_ready) begin
                s1_vld <= slv.exe_req_valid;
                if (slv.exe_req_valid) begin
                    s1_q.id      <= slv.exe_req.id;
                    s1_q.op      <= exe_d.op;
                    s1_q.en      <= exe_d.legal && op_enabled(exe_d.op);
                    s1_q.vd_addr <= slv.exe_req.instr[11:7];
                    s1_q.a       <= slv.exe_req.vs_data[0];
                    s1_q.b       <= slv.exe_req.vs_data[1];
                end
            end
        end
    end

    assign slv.exe_req_ready = exe_req_ready;
    assign slv.exe_rsp_valid = s2_vld;
    assign slv.exe_rsp       = s2_q;

endmodule

// File: tb/tb_xadac_vadd_unit.sv
// tb_xadac_vadd_unit: directed self-checking bench for xadac_vadd_unit.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_xadac_vadd_unit;
    import xadac_pkg::*;

    logic clk = 1'b0;
    logic rstn;

    xadac_if bus ();

    xadac_vadd_unit #(
        .LaneW8En  (1'b1),
        .LaneW16En (1'b1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .slv  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, XadacOpcVec};
    endfunction

    task automatic drive_exe(input logic v, input IdT id, input logic [31:0] instr,
                             input VecDataT a, input VecDataT b);
        bus.exe_req_valid      = v;
        bus.exe_req.id         = id;
        bus.exe_req.instr      = instr;
        bus.exe_req.vs_data[0] = a;
        bus.exe_req.vs_data[1] = b;
    endtask

    // One isolated op: checks the N+2 latency, payload, and single-cycle response.
    task automatic run_single(input string tag, input IdT id, input logic [2:0] f3,
                              input logic [4:0] rd, input VecDataT a, input VecDataT b,
                              input VecDataT exp_data, input logic exp_write);
        drive_exe(1'b1, id, mk_instr(XadacF7Vadd, f3, rd), a, b);
        #1;
        check({tag, " req_ready"}, bus.exe_req_ready, 1'b1);
        tick();
        drive_exe(1'b0, '0, '0, '0, '0);
        #1;
        check({tag, " no rsp at N+1"}, bus.exe_rsp_valid, 1'b0);
        tick();
        check({tag, " rsp valid at N+2"}, bus.exe_rsp_valid, 1'b1);
        check({tag, " id"}, bus.exe_rsp.id, id);
        check({tag, " vd_addr"}, bus.exe_rsp.vd_addr, rd);
        check({tag, " vd_data"}, bus.exe_rsp.vd_data, exp_data);
        check({tag, " vd_write"}, bus.exe_rsp.vd_write, exp_write);
        tick();
        check({tag, " rsp drained"}, bus.exe_rsp_valid, 1'b0);
    endtask

    int   next_id, rx, acc_cnt;
    logic acc;

    initial begin
        rstn              = 1'b0;
        bus.dec_req_valid = 1'b0;
        bus.dec_req       = '0;
        bus.dec_rsp_ready = 1'b1;
        bus.exe_rsp_ready = 1'b1;
        drive_exe(1'b0, '0, '0, '0, '0);

        // ---------------- reset state ----------------
        #2;
        check("reset dec_rsp_valid", bus.dec_rsp_valid, 1'b0);
        check("reset exe_rsp_valid", bus.exe_rsp_valid, 1'b0);
        check("reset dec_req_ready", bus.dec_req_ready, 1'b1);
        check("reset exe_req_ready", bus.exe_req_ready, 1'b1);
        check("reset vd_data", bus.exe_rsp.vd_data, '0);
        #11 rstn = 1'b1;
        tick();

        // ---------------- decode channel ----------------
        bus.dec_req_valid = 1'b1;
        bus.dec_req.id    = 4'd3;
        bus.dec_req.instr = mk_instr(XadacF7Vadd, F3Vadd8, 5'd1);
        #1;
        check("dec req_ready idle", bus.dec_req_ready, 1'b1);
        tick();
        check("dec vadd8 valid", bus.dec_rsp_valid, 1'b1);
        check("dec vadd8 id", bus.dec_rsp.id, 4'd3);
        check("dec vadd8 accept", bus.dec_rsp.accept, 1'b1);
        check("dec vadd8 vs_read", bus.dec_rsp.vs_read, 3'b011);
        check("dec vadd8 rs_read", bus.dec_rsp.rs_read, 2'b00);
        check("dec vadd8 vd_write", bus.dec_rsp.vd_write, 1'b1);
        bus.dec_req.id    = 4'd4;
        bus.dec_req.instr = mk_instr(7'h7F, F3Vadd8, 5'd1);
        tick();
        check("dec bad f7 valid", bus.dec_rsp_valid, 1'b1);
        check("dec bad f7 id", bus.dec_rsp.id, 4'd4);
        check("dec bad f7 accept", bus.dec_rsp.accept, 1'b0);
        check("dec bad f7 vd_write", bus.dec_rsp.vd_write, 1'b0);
        bus.dec_req.id    = 4'd5;
        bus.dec_req.instr = mk_instr(XadacF7Vadd, 3'd3, 5'd1);
        tick();
        check("dec bad f3 id", bus.dec_rsp.id, 4'd5);
        check("dec bad f3 accept", bus.dec_rsp.accept, 1'b0);
        bus.dec_req_valid = 1'b0;
        bus.dec_rsp_ready = 1'b0;
        #1;
        check("dec stall req_ready", bus.dec_req_ready, 1'b0);
        tick();
        check("dec stall held valid", bus.dec_rsp_valid, 1'b1);
        check("dec stall held id", bus.dec_rsp.id, 4'd5);
        bus.dec_rsp_ready = 1'b1;
        tick();
        check("dec drained", bus.dec_rsp_valid, 1'b0);

        // ---------------- single ops ----------------
        run_single("vadd8", 4'd1, F3Vadd8, 5'd5,
                   {8'h80, 104'h0, 16'h10FF}, {8'h80, 104'h0, 16'h2001},
                   {8'h00, 104'h0, 16'h3000}, 1'b1);
        run_single("vsub16", 4'd2, F3Vsub16, 5'd6,
                   '0, {8{16'h0001}}, {8{16'hFFFF}}, 1'b1);
        run_single("vadd32", 4'd3, F3Vadd32, 5'd7,
                   {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, {4{32'h8000_0000}}, 1'b1);
        run_single("vsub8", 4'd4, F3Vsub8, 5'd8,
                   '0, {16{8'h01}}, {16{8'hFF}}, 1'b1);
        run_single("vadd16", 4'd6, F3Vadd16, 5'd10,
                   {8{16'hFFFF}}, {8{16'h0002}}, {8{16'h0001}}, 1'b1);
        run_single("illegal f3", 4'd5, 3'd3, 5'd9,
                   {4{32'h1234_5678}}, {4{32'h1111_1111}}, '0, 1'b0);

        // ---------------- back-to-back ----------------
        for (int c = 0; c < 10; c++) begin
            if (c < 8)
                drive_exe(1'b1, IdT'(c), mk_instr(XadacF7Vadd, F3Vadd32, 5'(c)),
                          {4{32'(c)}}, {4{32'd100}});
            else
                drive_exe(1'b0, '0, '0, '0, '0);
            #1;
            if (c < 8) check("b2b req_ready", bus.exe_req_ready, 1'b1);
            tick();
            check("b2b rsp valid", bus.exe_rsp_valid, (c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) begin
                check("b2b id order", bus.exe_rsp.id, IdT'(c - 1));
                check("b2b data", bus.exe_rsp.vd_data, {4{32'(c - 1 + 100)}});
            end
        end

        // ---------------- backpressure ----------------
        next_id = 1;
        rx      = 0;
        acc_cnt = 0;
        for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
            bus.exe_rsp_ready = (cyc >= 5);
            if (next_id <= 4)
                drive_exe(1'b1, IdT'(next_id),
                          mk_instr(XadacF7Vadd, F3Vadd16, 5'(next_id + 10)),
                          {4{32'(next_id)}}, {4{32'h0001_0001}});
            else
                drive_exe(1'b0, '0, '0, '0, '0);
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp full req_ready", bus.exe_req_ready, 1'b0);
                check("bp hold valid", bus.exe_rsp_valid, 1'b1);
                check("bp hold id", bus.exe_rsp.id, 4'd1);
                check("bp hold data", bus.exe_rsp.vd_data, {4{16'h0001, 16'h0002}});
            end
            if (cyc == 5) check("bp accepts before full", acc_cnt, 2);
            if (bus.exe_rsp_valid && bus.exe_rsp_ready) begin
                rx++;
                check("bp rsp id", bus.exe_rsp.id, IdT'(rx));
                check("bp rsp vd_addr", bus.exe_rsp.vd_addr, 5'(rx + 10));
                check("bp rsp data", bus.exe_rsp.vd_data, {4{16'h0001, 16'(rx + 1)}});
            end
            acc = bus.exe_req_valid && bus.exe_req_ready;
            tick();
            if (acc) begin
                next_id++;
                acc_cnt++;
            end
        end
        check("bp all responses", rx, 4);
        drive_exe(1'b0, '0, '0, '0, '0);
        tick();
        check("bp idle", bus.exe_rsp_valid, 1'b0);

        // ---------------- reset mid-operation ----------------
        bus.exe_rsp_ready = 1'b0;
        drive_exe(1'b1, 4'd6, mk_instr(XadacF7Vadd, F3Vadd32, 5'd1), '1, '1);
        tick();
        drive_exe(1'b1, 4'd7, mk_instr(XadacF7Vadd, F3Vadd32, 5'd2), '1, '1);
        tick();
        drive_exe(1'b0, '0, '0, '0, '0);
        #1;
        check("rst in-flight valid", bus.exe_rsp_valid, 1'b1);
        rstn = 1'b0;
        #1;
        check("rst exe_rsp_valid", bus.exe_rsp_valid, 1'b0);
        check("rst exe_req_ready", bus.exe_req_ready, 1'b1);
        check("rst vd_data", bus.exe_rsp.vd_data, '0);
        tick();
        #2 rstn = 1'b1;
        bus.exe_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst no stale rsp", bus.exe_rsp_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
